// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------
// arb_pkg : shared constants and types for the 16-way arbiter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package arb_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Pointer starts at the top index so requester 0 is searched first.
  localparam logic [IDX_W-1:0] PTR_RESET = 4'd15;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter_16_pick.sv
// ---------------------------------------------------------------
// rr_pick : first eligible requester above ptr, wrapping 15 -> 0
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0]   offset;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   low;

  // Rotating by ptr+1 puts the next requester in line at bit 0.
  assign offset = ptr_i + 1'b1;
  assign dbl    = {elig_i, elig_i} >> offset;
  assign rot    = dbl[N_REQ-1:0];

  always_comb begin
    low = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) low = IDX_W'(i);
    end
  end

  assign found_o = |elig_i;
  assign idx_o   = low + offset;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_16.sv
// ---------------------------------------------------------------
// rr_arbiter_16 : 16-requester round-robin arbiter with pending
//                 request capture, release handshake and hold timeout
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module rr_arbiter_16
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_i,
  input  logic [N_REQ-1:0]  mask_i,
  input  logic              done_i,
  output logic              gnt_valid_o,
  output logic [IDX_W-1:0]  gnt_idx_o,
  output logic [N_REQ-1:0]  gnt_onehot_o,
  output logic [N_REQ-1:0]  pending_o,
  output logic              timeout_o
);

  localparam int unsigned CNT_W = (HOLD_MAX <= 1) ? 1 : $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_REQ-1:0]  onehot_q, onehot_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  clear;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  // Same-cycle requests are eligible immediately, before they land in pending.
  assign elig = (pending_q | req_i) & ~mask_i;

  rr_pick u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    onehot_d  = onehot_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    clear     = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = GRANT;
          idx_d    = pick_idx;
          ptr_d    = pick_idx;
          cnt_d    = '0;
          clear    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          onehot_d = clear;
        end
      end
      GRANT: begin
        // A release on the timeout edge counts as normal, so done_i is tested first.
        if (done_i) begin
          state_d  = IDLE;
          onehot_d = '0;
        end else if ((HOLD_MAX != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = IDLE;
          onehot_d  = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
      end
    endcase

    pending_d = (pending_q | req_i) & ~clear;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RESET;
      idx_q     <= '0;
      onehot_q  <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      onehot_q  <= onehot_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_valid_o  = (state_q == GRANT);
  assign gnt_idx_o    = idx_q;
  assign gnt_onehot_o = onehot_q;
  assign pending_o    = pending_q;
  assign timeout_o    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_16.sv
// ---------------------------------------------------------------
// tb_rr_arbiter_16 : table, directed and randomized checks of rr_arbiter_16
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter_16;

  localparam int HM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req_i, mask_i;
  logic        done_i;
  logic        gnt_valid_o;
  logic [3:0]  gnt_idx_o;
  logic [15:0] gnt_onehot_o, pending_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  rr_arbiter_16 #(.HOLD_MAX(HM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .mask_i       (mask_i),
    .done_i       (done_i),
    .gnt_valid_o  (gnt_valid_o),
    .gnt_idx_o    (gnt_idx_o),
    .gnt_onehot_o (gnt_onehot_o),
    .pending_o    (pending_o),
    .timeout_o    (timeout_o)
  );

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endfunction

  // Reference model: who holds the grant, how long, and which bits wait.
  bit          m_gnt;
  int          m_idx, m_ptr, m_cnt;
  bit [15:0]   m_pend;
  bit          m_to;

  function automatic void model_reset();
    m_gnt = 0; m_idx = 0; m_ptr = 15; m_cnt = 0; m_pend = '0; m_to = 0;
  endfunction

  function automatic void model_edge(bit [15:0] r, bit [15:0] m, bit d);
    bit [15:0] elig = (m_pend | r) & ~m;
    bit [15:0] clr = '0;
    m_to = 0;
    if (!m_gnt) begin
      for (int k = 1; k <= 16; k++) begin
        int j = (m_ptr + k) % 16;
        if (elig[j]) begin
          m_gnt = 1; m_idx = j; m_ptr = j; m_cnt = 0; clr[j] = 1'b1;
          break;
        end
      end
    end else if (d) begin
      m_gnt = 0;
    end else if (m_cnt == HM - 1) begin
      m_gnt = 0; m_to = 1;
    end else begin
      m_cnt++;
    end
    m_pend = (m_pend | r) & ~clr;
  endfunction

  task automatic step(input logic [15:0] r, input logic [15:0] m, input logic d);
    req_i = r; mask_i = m; done_i = d;
    model_edge(r, m, d);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input bit v, input int idx,
                            input logic [15:0] pend, input bit to);
    logic [15:0] oh;
    logic [15:0] one;
    one = 16'h0001;
    oh = v ? (one << idx) : 16'h0000;
    chk({tag, "_valid"}, 32'(gnt_valid_o), 32'(v));
    if (v) chk({tag, "_idx"}, 32'(gnt_idx_o), 32'(idx));
    chk({tag, "_onehot"}, 32'(gnt_onehot_o), 32'(oh));
    chk({tag, "_pending"}, 32'(pending_o), 32'(pend));
    chk({tag, "_timeout"}, 32'(timeout_o), 32'(to));
  endtask

  typedef struct {
    logic [15:0] req;
    logic [15:0] mask;
    logic        done;
    bit          ev;
    int          eidx;
    logic [15:0] epend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [15:0] r, logic [15:0] m, logic d,
                              bit ev, int eidx, logic [15:0] ep);
    vec_t t;
    t.req = r; t.mask = m; t.done = d; t.ev = ev; t.eidx = eidx; t.epend = ep;
    return t;
  endfunction

  initial begin
    logic [15:0] rmask;
    rst_n = 1'b0; req_i = '0; mask_i = '0; done_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 16'h0000, 0);
    chk("reset_idx", 32'(gnt_idx_o), 32'd0);
    rst_n = 1'b1;

    // Single grant, 0/8/15 rotation, masking, idle done.
    tbl.push_back(mk(16'h0001, 16'h0000, 0, 1, 0,  16'h0000));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 0, 0,  16'h0000));
    tbl.push_back(mk(16'h8101, 16'h0000, 0, 1, 8,  16'h8001));
    tbl.push_back(mk(16'h8101, 16'h0000, 1, 0, 0,  16'h8101));
    tbl.push_back(mk(16'h8101, 16'h0000, 0, 1, 15, 16'h0101));
    tbl.push_back(mk(16'h8101, 16'h0000, 1, 0, 0,  16'h8101));
    tbl.push_back(mk(16'h8101, 16'h0000, 0, 1, 0,  16'h8100));
    tbl.push_back(mk(16'h8101, 16'h0000, 1, 0, 0,  16'h8101));
    tbl.push_back(mk(16'h8101, 16'h0000, 0, 1, 8,  16'h8001));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 0, 0,  16'h8001));
    tbl.push_back(mk(16'h0000, 16'hFFFF, 0, 0, 0,  16'h8001));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 1, 15, 16'h0001));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 0, 0,  16'h0001));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 1, 0,  16'h0000));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 0, 0,  16'h0000));
    tbl.push_back(mk(16'h0002, 16'h0002, 0, 0, 0,  16'h0002));
    tbl.push_back(mk(16'h0000, 16'h0002, 0, 0, 0,  16'h0002));
    tbl.push_back(mk(16'h0000, 16'h0000, 0, 1, 1,  16'h0000));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 0, 0,  16'h0000));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 0, 0,  16'h0000));

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].mask, tbl[i].done);
      expect_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].eidx, tbl[i].epend, 0);
    end

    // Re-request of the current grantee.
    step(16'h0008, 16'h0000, 0); expect_out("rereq_gnt", 1, 3, 16'h0000, 0);
    step(16'h0008, 16'h0000, 0); expect_out("rereq_set", 1, 3, 16'h0008, 0);
    step(16'h0000, 16'h0000, 1); expect_out("rereq_rel", 0, 0, 16'h0008, 0);
    step(16'h0000, 16'h0000, 0); expect_out("rereq_again", 1, 3, 16'h0000, 0);
    step(16'h0000, 16'h0000, 1); expect_out("rereq_rel2", 0, 0, 16'h0000, 0);

    // Hold timeout: exactly HM grant cycles, then a one-cycle pulse.
    step(16'h0020, 16'h0000, 0); expect_out("hold_c0", 1, 5, 16'h0000, 0);
    for (int k = 1; k < HM; k++) begin
      step(16'h0000, 16'h0000, 0);
      expect_out($sformatf("hold_c%0d", k), 1, 5, 16'h0000, 0);
    end
    step(16'h0000, 16'h0000, 0); expect_out("hold_to", 0, 0, 16'h0000, 1);
    step(16'h0000, 16'h0000, 0); expect_out("hold_after", 0, 0, 16'h0000, 0);

    // done_i on the timeout edge is a plain release.
    step(16'h0020, 16'h0000, 0); expect_out("dto_gnt", 1, 5, 16'h0000, 0);
    for (int k = 1; k < HM; k++) step(16'h0000, 16'h0000, 0);
    step(16'h0000, 16'h0000, 1); expect_out("dto_rel", 0, 0, 16'h0000, 0);

    // Asynchronous reset in the middle of a grant.
    step(16'h0080, 16'h0000, 0); expect_out("rst_gnt", 1, 7, 16'h0000, 0);
    step(16'h00F0, 16'h0000, 0); expect_out("rst_pend", 1, 7, 16'h00F0, 0);
    req_i = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    expect_out("rst_async", 0, 0, 16'h0000, 0);
    chk("rst_async_idx", 32'(gnt_idx_o), 32'd0);
    #1 rst_n = 1'b1;
    step(16'h0081, 16'h0000, 0); expect_out("rst_after", 1, 0, 16'h0080, 0);
    step(16'h0000, 16'h0000, 1); expect_out("rst_rel", 0, 0, 16'h0080, 0);

    // Randomized traffic against the model.
    rmask = '0;
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] r;
      logic        d;
      if (c % 64 == 0)
        rmask = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom & $urandom & $urandom);
      r = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom) : 16'h0000;
      d = ($urandom_range(0, 4) == 0);
      step(r, rmask, d);
      chk("rnd_valid", 32'(gnt_valid_o), 32'(m_gnt));
      if (m_gnt) chk("rnd_idx", 32'(gnt_idx_o), 32'(m_idx));
      chk("rnd_onehot", 32'(gnt_onehot_o), m_gnt ? (32'd1 << m_idx) : 32'd0);
      chk("rnd_pending", 32'(pending_o), 32'(m_pend));
      chk("rnd_timeout", 32'(timeout_o), 32'(m_to));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Sixteen-requester round-robin arbiter that shares one downstream resource (the priority-encoded datapath port) fairly between requesters, replacing fixed highest-index-wins selection. It latches request pulses into a pending vector, grants one requester at a time with a release handshake, and bounds grant tenure with a hold timeout. It sits between the request sources and the shared resource inside the user project top.

## Interface
- `N`, 16: number of requesters (fixed at 16 for this design; `IDX_W` = 4).
- `HOLD_MAX`, 64: maximum cycles a grant may be held before forced release; 0 disables the timeout.
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_i`  in  16: request pulses/levels, one bit per requester; any high sample sets that pending bit.
- `mask_i`  in  16: 1 = requester disabled for arbitration (pending bit retained, not granted).
- `done_i`  in  1: current grantee releases the resource.
- `gnt_valid_o`  out  1: a grant is active.
- `gnt_idx_o`  out  4: index of grantee; valid only when `gnt_valid_o`.
- `gnt_onehot_o`  out  16: one-hot grant; all-zero when no grant.
- `pending_o`  out  16: current pending vector.
- `timeout_o`  out  1: one-cycle pulse on forced release.

## Operation
- States: IDLE, GRANT. Reset → IDLE.
- Eligible vector E = (pending | req_i) & ~mask_i.
- IDLE: if E ≠ 0, pick the first set bit of E searching upward from ptr+1 with wrap 15→0; on the edge: state → GRANT, gnt_idx ← pick, ptr ← pick, pending[pick] ← 0, hold counter ← 0. If E = 0, stay IDLE.
- GRANT: done_i → IDLE on the next edge. Else if HOLD_MAX ≠ 0 and counter = HOLD_MAX−1 → IDLE with timeout_o = 1 in the following cycle. Else counter increments (saturating width ⌈log2(HOLD_MAX)⌉, minimum 1 bit).
- Pending update every edge: pending ← (pending | req_i) & ~clear, where clear is the one-hot of the bit granted on this edge. A req_i on the grantee's index during the grant-edge cycle is consumed by that grant (clear wins). A req_i on that index during GRANT sets pending again (re-request).
- Masked bits keep accumulating into pending; unmasking makes them eligible in the next IDLE cycle.
- done_i in IDLE is ignored. done_i and timeout on the same edge: treated as a normal release, timeout_o stays 0.
- Reset values: state IDLE, ptr = 15 (index 0 has priority first), pending = 0, counter = 0, gnt_valid_o = 0, gnt_idx_o = 0, gnt_onehot_o = 0, timeout_o = 0.
- Reset asserted mid-grant: immediate return to all reset values, with no timeout pulse.

## Timing
- Request-to-grant latency: req_i high in IDLE cycle t → gnt_valid_o high in cycle t+1.
- After a release, the arbiter spends at least one IDLE cycle, so back-to-back grants have a 1-cycle gap with gnt_valid_o low.
- Release: done_i high in cycle t → gnt_valid_o low in cycle t+1.
- Timeout: a grant lasts exactly HOLD_MAX cycles if done_i never rises. timeout_o is high in the first IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `arb_pkg`: `N_REQ` = 16, `IDX_W` = 4, state enum {IDLE, GRANT}, `PTR_RESET` = 15.
- One combinational sub-module, `rr_pick`: takes E and ptr, returns a found flag and a 4-bit index. Implementation: rotate E right by ptr+1, take the lowest-index set bit, then add ptr+1 mod 16.
- The top contains the FSM, pending register, pointer and hold counter.

## Test plan
- Reset, then req_i = 0x0001 for one cycle → next cycle gnt_valid_o = 1, gnt_idx_o = 0, gnt_onehot_o = 0x0001, pending_o = 0x0000.
- req_i = 0x8101 held steady, done_i pulsed one cycle after each grant → grant order 0, 8, 15, 0, 8, … with one idle cycle between grants.
- Grant index 3, req_i[3] pulses during GRANT, then done_i → pending_o = 0x0008 after the pulse; index 3 is granted again after the idle cycle.
- HOLD_MAX = 4, single request at index 5, done_i never asserted → gnt_valid_o high for exactly 4 cycles, then timeout_o high for 1 cycle while gnt_valid_o = 0.
- mask_i = 0x0002, req_i pulse = 0x0002 → no grant and pending_o = 0x0002; clear the mask → grant of index 1 the next cycle.
- rst_n dropped while granting index 7 with pending_o = 0x00F0 → all outputs 0 immediately. After reset release, req_i = 0x0081 → grant index 0 first.
